// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 set-2 make/break byte sequences and tracks a configurable set of keys,
// producing per-key hold/toggle state, press/release pulses and protocol error pulses.
module ps2_key_tracker #(
    parameter int                      NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*9-1:0]   KEY_CODES      = {9'h1_74, 9'h1_6B, 9'h0_29, 9'h0_5A},
    parameter logic [NUM_KEYS-1:0]     TOGGLE_MASK    = '0,
    parameter int                      TIMEOUT_CYCLES = 100000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_held,
    output logic [8:0]          last_code,
    output logic                seq_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] keyState_q, keyState_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic                anyHeld_q;
    logic [8:0]          lastCode_q, lastCode_d;
    logic                seqError_q, seqError_d;

    logic                complete;
    logic                isBreak;
    logic                extFlag;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            held_q     <= '0;
            keyState_q <= '0;
            press_q    <= '0;
            release_q  <= '0;
            anyHeld_q  <= 1'b0;
            lastCode_q <= 9'h000;
            seqError_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            held_q     <= held_d;
            keyState_q <= keyState_d;
            press_q    <= press_d;
            release_q  <= release_d;
            anyHeld_q  <= |held_d;
            lastCode_q <= lastCode_d;
            seqError_q <= seqError_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        complete   = 1'b0;
        isBreak    = 1'b0;
        extFlag    = 1'b0;
        seqError_d = 1'b0;
        if (rx_valid) begin
            cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (rx_data == BYTE_EXT)      state_d = EXT;
                    else if (rx_data == BYTE_BRK) state_d = BRK;
                    else                          complete = 1'b1;
                end
                EXT: begin
                    if (rx_data == BYTE_BRK) begin
                        state_d = EXT_BRK;
                    end else if (rx_data == BYTE_EXT) begin
                        seqError_d = 1'b1;
                    end else begin
                        complete = 1'b1;
                        extFlag  = 1'b1;
                        state_d  = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    if (rx_data == BYTE_BRK) begin
                        seqError_d = 1'b1;
                        state_d    = IDLE;
                    end else if (rx_data == BYTE_EXT) begin
                        seqError_d = 1'b1;
                        state_d    = EXT;
                    end else begin
                        complete = 1'b1;
                        isBreak  = 1'b1;
                        extFlag  = (state_q == EXT_BRK);
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // Stalled mid-sequence: drop the partial bytes and flag it
            seqError_d = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        held_d     = held_q;
        keyState_d = keyState_q;
        press_d    = '0;
        release_d  = '0;
        lastCode_d = complete ? {extFlag, rx_data} : lastCode_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (complete && ({extFlag, rx_data} == KEY_CODES[9*i +: 9])) begin
                held_d[i] = ~isBreak;
            end
            press_d[i]   = held_d[i] & ~held_q[i];
            release_d[i] = ~held_d[i] & held_q[i];
            keyState_d[i] = TOGGLE_MASK[i] ? (keyState_q[i] ^ press_d[i]) : held_d[i];
        end
    end

    assign key_state   = keyState_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign any_held    = anyHeld_q;
    assign last_code   = lastCode_q;
    assign seq_error   = seqError_q;

endmodule
